// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command FIFO feeding the 8-bit ALU through its
// load/persist protocol, then returning captured results in order.
// Optional feature macro: ALU_SEQ_ONEHOT_CHECK_EN (one-hot op checking;
// illegal ops bypass the ALU and return res_data=0, res_err=1).
module alu_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int WIDTH   = 8,
   parameter int OP_W    = 7,
   parameter int ALU_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [WIDTH-1:0]         cmd_a,
   input  logic [WIDTH-1:0]         cmd_b,
   input  logic [OP_W-1:0]          cmd_op,
   output logic                     alu_on,
   output logic [2:0]               alu_in_sel,
   output logic [WIDTH-1:0]         alu_num1,
   output logic [WIDTH-1:0]         alu_num2,
   output logic [OP_W-1:0]          alu_out_sel,
   input  logic [WIDTH-1:0]         alu_out,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_data,
   output logic                     res_err,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   localparam logic [2:0] SEL_PERSIST = 3'b100;
   localparam logic [2:0] SEL_LOAD    = 3'b010;
   localparam logic [2:0] SEL_RESET   = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t state_reg, state_next;

   // Command storage; read into the operand registers on pop.
   logic [WIDTH-1:0] mem_a  [DEPTH];
   logic [WIDTH-1:0] mem_b  [DEPTH];
   logic [OP_W-1:0]  mem_op [DEPTH];

   logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic             push, pop, fifo_empty, head_illegal, capture;
   logic [CW-1:0]    wait_cnt_reg;

   logic             alu_on_reg;
   logic [2:0]       alu_in_sel_reg;
   logic [WIDTH-1:0] num1_reg, num2_reg;
   logic [OP_W-1:0]  out_sel_reg;
   logic             res_valid_reg;
   logic [WIDTH-1:0] res_data_reg;

   assign fifo_empty  = (level_reg == '0);
   // Full check only; a same-cycle pop does not free a slot early.
   assign cmd_ready   = rst && (level_reg != LW'(DEPTH));
   assign push        = cmd_valid && cmd_ready;

   assign level       = level_reg;
   assign alu_on      = alu_on_reg;
   assign alu_in_sel  = alu_in_sel_reg;
   assign alu_num1    = num1_reg;
   assign alu_num2    = num2_reg;
   assign alu_out_sel = out_sel_reg;
   assign res_valid   = res_valid_reg;
   assign res_data    = res_data_reg;

   // Write incoming commands into the storage array.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr_reg]  <= cmd_a;
         mem_b[wr_ptr_reg]  <= cmd_b;
         mem_op[wr_ptr_reg] <= cmd_op;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

`ifdef ALU_SEQ_ONEHOT_CHECK_EN
   // Legality is decided at push time and kept per entry so the FSM can
   // branch on the head entry without an asynchronous read of the data array.
   logic [DEPTH-1:0] illegal_reg;
   logic             cmd_illegal;
   logic             res_err_reg;

   assign cmd_illegal  = (cmd_op == '0) || ((cmd_op & (cmd_op - OP_W'(1))) != '0);
   assign head_illegal = illegal_reg[rd_ptr_reg];
   assign res_err      = res_err_reg;

   // Per-entry illegal-op flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         illegal_reg <= '0;
      end else if (push) begin
         illegal_reg[wr_ptr_reg] <= cmd_illegal;
      end
   end

   // Error flag follows the result it belongs to.
   always_ff @(posedge clk) begin
      if (!rst) begin
         res_err_reg <= 1'b0;
      end else if (capture) begin
         res_err_reg <= 1'b0;
      end else if (pop && head_illegal) begin
         res_err_reg <= 1'b1;
      end
   end
`else
   // Without checking every op is forwarded to the ALU.
   assign head_illegal = 1'b0;
   assign res_err      = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic, pop and capture strobes.
   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = head_illegal ? S_HOLD : S_LOAD;
            end
         end
         S_LOAD: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt_reg == '0) begin
               capture    = 1'b1;
               state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (res_ready) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_next = head_illegal ? S_HOLD : S_LOAD;
               end else begin
                  state_next = S_IDLE;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ALU drive, latency counter and result registers, all registered off the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_on_reg     <= 1'b0;
         alu_in_sel_reg <= SEL_RESET;
         num1_reg       <= '0;
         num2_reg       <= '0;
         out_sel_reg    <= '0;
         wait_cnt_reg   <= '0;
         res_valid_reg  <= 1'b0;
         res_data_reg   <= '0;
      end else begin
         alu_in_sel_reg <= (state_next == S_LOAD) ? SEL_LOAD : SEL_PERSIST;
         alu_on_reg     <= (state_next == S_LOAD) || (state_next == S_WAIT);
         res_valid_reg  <= (state_next == S_HOLD);

         if (pop && !head_illegal) begin
            num1_reg    <= mem_a[rd_ptr_reg];
            num2_reg    <= mem_b[rd_ptr_reg];
            out_sel_reg <= mem_op[rd_ptr_reg];
         end

         if (state_reg == S_LOAD) begin
            wait_cnt_reg <= CW'(ALU_LAT - 1);
         end else if (state_reg == S_WAIT && wait_cnt_reg != '0) begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
         end

         if (capture) begin
            res_data_reg <= alu_out;
         end else if (pop && head_illegal) begin
            res_data_reg <= '0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a registered-add ALU model.
module tb_alu_cmd_sequencer;

   localparam int DEPTH   = 4;
   localparam int WIDTH   = 8;
   localparam int OP_W    = 7;
   localparam int ALU_LAT = 1;
   localparam logic [OP_W-1:0] OP_ADD = 7'b1000000;
   localparam logic [OP_W-1:0] OP_BAD = 7'b0000011;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_a, cmd_b;
   logic [OP_W-1:0]  cmd_op;
   logic             alu_on;
   logic [2:0]       alu_in_sel;
   logic [WIDTH-1:0] alu_num1, alu_num2;
   logic [OP_W-1:0]  alu_out_sel;
   logic [WIDTH-1:0] alu_out;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_err;
   logic [$clog2(DEPTH):0] level;

   int n_cmp = 0;
   int n_err = 0;
   int exp_q [8];

   alu_cmd_sequencer #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .OP_W(OP_W), .ALU_LAT(ALU_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_on(alu_on), .alu_in_sel(alu_in_sel),
      .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_sel(alu_out_sel),
      .alu_out(alu_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_err(res_err),
      .level(level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: registered add on a load, holds its output otherwise.
   initial alu_out = '0;
   always @(posedge clk) begin
      if (alu_on && alu_in_sel == 3'b010) alu_out <= alu_num1 + alu_num2;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [OP_W-1:0] op);
      int t;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 20) begin
         tick();
         t++;
      end
      check("push_ready", cmd_ready, 1);
      tick();
      $display("push a=0x%02h b=0x%02h op=%b", a, b, op);
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input int n, input int spacing);
      int got, last, cyc;
      got = 0; last = 0; cyc = 0;
      while (got < n && cyc < 60) begin
         if (res_valid && res_ready) begin
            $display("result[%0d] data=0x%02h err=%0b cycle=%0d", got, res_data, res_err, cyc);
            check($sformatf("res_data[%0d]", got), res_data, exp_q[got]);
            if (spacing > 0 && got > 0) check($sformatf("spacing[%0d]", got), cyc - last, spacing);
            last = cyc;
            got++;
         end
         tick();
         cyc++;
      end
      check("drain_count", got, n);
   endtask

   initial begin
      logic saw_load, saw_valid, got_res;
      logic [WIDTH-1:0] cap_data;
      logic cap_err;
      logic [WIDTH-1:0] ill_data;
      logic ill_err, ill_load;

      rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_op = '0;

      // Reset held for two cycles
      tick(); tick();
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_in_sel", alu_in_sel, 3'b001);
      check("rst_res_valid", res_valid, 0);
      check("rst_level", level, 0);
      check("rst_alu_on", alu_on, 0);
      rst = 1'b1;
      #1;
      check("rel_cmd_ready", cmd_ready, 1);
      tick();
      check("rel_in_sel", alu_in_sel, 3'b100);

      // Single op 0x57 + 0x1A
      res_ready = 1'b1;
      cmd_a = 8'h57; cmd_b = 8'h1A; cmd_op = OP_ADD; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      $display("single: accepted a=0x57 b=0x1a");
      check("single_level", level, 1);
      check("single_sel0", alu_in_sel, 3'b100);
      tick();
      check("single_sel_load", alu_in_sel, 3'b010);
      check("single_on", alu_on, 1);
      check("single_num1", alu_num1, 8'h57);
      check("single_num2", alu_num2, 8'h1A);
      check("single_out_sel", alu_out_sel, OP_ADD);
      tick();
      check("single_sel_wait", alu_in_sel, 3'b100);
      check("single_not_valid", res_valid, 0);
      tick();
      check("single_valid", res_valid, 1);
      check("single_data", res_data, 8'h71);
      check("single_err", res_err, 0);
      tick();
      check("single_valid_drop", res_valid, 0);

      // Backpressure until the FIFO fills
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_a = 8'(8'h10 + i); cmd_b = 8'(i); cmd_op = OP_ADD; cmd_valid = 1'b1;
         check($sformatf("bp_ready[%0d]", i), cmd_ready, 1);
         tick();
         $display("bp push %0d level=%0d", i, level);
         exp_q[i] = 32'h10 + 2 * i;
      end
      cmd_a = 8'hEE; cmd_b = 8'hEE;
      check("full_ready", cmd_ready, 0);
      check("full_level", level, 4);
      check("full_res_valid", res_valid, 1);
      check("full_res_data", res_data, 8'h10);
      tick(); tick();
      check("full_level_held", level, 4);
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      drain(5, 3);
      check("bp_empty_level", level, 0);
      check("bp_valid_drop", res_valid, 0);

      // Back-to-back adds
      push_cmd(8'd1, 8'd2, OP_ADD);
      push_cmd(8'd3, 8'd4, OP_ADD);
      push_cmd(8'd5, 8'd6, OP_ADD);
      exp_q[0] = 3; exp_q[1] = 7; exp_q[2] = 11;
      drain(3, 3);

      // Illegal (two-hot) op
`ifdef ALU_SEQ_ONEHOT_CHECK_EN
      ill_data = 8'h00; ill_err = 1'b1; ill_load = 1'b0;
`else
      ill_data = 8'h33; ill_err = 1'b0; ill_load = 1'b1;
`endif
      push_cmd(8'h22, 8'h11, OP_BAD);
      saw_load = 1'b0; got_res = 1'b0; cap_data = '0; cap_err = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (alu_in_sel == 3'b010) saw_load = 1'b1;
         if (res_valid && !got_res) begin
            got_res = 1'b1; cap_data = res_data; cap_err = res_err;
         end
         tick();
      end
      $display("illegal: data=0x%02h err=%0b load_seen=%0b", cap_data, cap_err, saw_load);
      check("ill_got", got_res, 1);
      check("ill_data", cap_data, ill_data);
      check("ill_err", cap_err, ill_err);
      check("ill_load_seen", saw_load, ill_load);

      // Reset during WAIT with two commands queued
      res_ready = 1'b0;
      push_cmd(8'h01, 8'h01, OP_ADD);
      push_cmd(8'h02, 8'h02, OP_ADD);
      push_cmd(8'h03, 8'h03, OP_ADD);
      check("mid_level", level, 2);
      check("mid_not_valid", res_valid, 0);
      rst = 1'b0;
      tick();
      check("mid_rst_sel", alu_in_sel, 3'b001);
      check("mid_rst_level", level, 0);
      check("mid_rst_ready", cmd_ready, 0);
      rst = 1'b1;
      res_ready = 1'b1;
      tick();
      check("mid_rel_sel", alu_in_sel, 3'b100);
      saw_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (res_valid) saw_valid = 1'b1;
         tick();
      end
      $display("after mid-wait reset: valid_seen=%0b level=%0d", saw_valid, level);
      check("mid_no_valid", saw_valid, 0);
      check("mid_final_level", level, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command stage for the 8-bit ALU (`main`). It accepts operand/operation commands over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU's `on`/`in_sel`/`num1`/`num2`/`out_sel` inputs using the load/persist protocol, then captures `out` after a fixed latency. Results are returned in order on a second valid/ready handshake.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `WIDTH`, 8: operand/result width
- `OP_W`, 7: one-hot operation select width
- `ALU_LAT`, 1: cycles from the ALU sampling a load until `alu_out` is valid (≥1)

Ports:
- `clk` in 1: the block's single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: FIFO can accept
- `cmd_a` in WIDTH: operand 1
- `cmd_b` in WIDTH: operand 2
- `cmd_op` in OP_W: one-hot operation
- `alu_on` out 1: to ALU `on`
- `alu_in_sel` out 3: to ALU `in_sel`; 3'b100 persist, 3'b010 load, 3'b001 reset
- `alu_num1` / `alu_num2` out WIDTH: ALU operands
- `alu_out_sel` out OP_W: ALU operation select
- `alu_out` in WIDTH: ALU result
- `res_valid` out 1: result present
- `res_ready` in 1: consumer accepts
- `res_data` out WIDTH: captured result
- `res_err` out 1: command had an illegal op
- `level` out $clog2(DEPTH)+1: FIFO occupancy

## Operation
- **Reset** (`rst`=0 at an edge): FIFO emptied; `level`=0; state IDLE; `alu_on`=0; `alu_in_sel`=3'b001; operands and `alu_out_sel` = 0; `res_valid`=0, `res_data`=0, `res_err`=0. In-flight and queued commands are discarded.
- `cmd_ready` = `rst` && (`level` != DEPTH). Combinational; it does not look ahead at a same-cycle pop.
- A push occurs when `cmd_valid`&&`cmd_ready` at an edge. A simultaneous push and pop leaves `level` unchanged.
- **FSM** (2-bit, registered, Moore outputs):
  - **IDLE**:
    - Outputs: `alu_on`=0, `alu_in_sel`=100.
    - If FIFO non-empty: pop. Go to LOAD for a legal op, or to HOLD for an illegal op.
  - **LOAD** (exactly 1 cycle):
    - Outputs: `alu_on`=1, `alu_in_sel`=010; num1/num2/out_sel from the popped entry.
    - Next state: WAIT.
  - **WAIT** (ALU_LAT cycles, down-counter):
    - Outputs: `alu_in_sel`=100; operands held.
    - On the last cycle: `res_data`<=`alu_out`, `res_err`<=0, `res_valid`<=1, go to HOLD.
  - **HOLD**:
    - `res_valid`=1; `res_data` and `res_err` held stable until `res_valid`&&`res_ready`.
    - On that handshake: if FIFO non-empty, pop and go to LOAD (or stay in HOLD with the new error result for an illegal op). Otherwise go to IDLE and `res_valid`<=0.
- Illegal op (`cmd_op` not exactly one bit set, including all-zero) is handled per Configuration. No ALU load is issued for it.
- Results are delivered strictly in acceptance order. No command is dropped except by reset.

## Timing
- Empty, idle block; command accepted at edge E:
  - `alu_in_sel`=010 during cycle after E+1.
  - WAIT from E+2.
  - `res_valid`=1 after edge E+2+ALU_LAT (ALU_LAT=1: after E+3).
- Sustained throughput with `res_ready`=1 and a non-empty FIFO: one result per ALU_LAT+2 cycles.
- `res_valid` drops the cycle after the final handshake.
- Illegal op from IDLE: `res_valid`=1 one edge after the pop.
- The ALU is assumed to sample `in_sel`=010 at the edge ending LOAD.

## Configuration
- `ALU_SEQ_ONEHOT_CHECK_EN` defined: illegal ops bypass the ALU and produce `res_data`=0, `res_err`=1.
- Not defined: every op is treated as legal and forwarded through LOAD/WAIT unchanged; `res_err` is tied to 0.

## Test plan
- **Reset**: hold `rst`=0 for 2 cycles → `cmd_ready`=0, `alu_in_sel`=001, `res_valid`=0, `level`=0. Release → `cmd_ready`=1, `alu_in_sel`=100.
- **Single op**: a=0x57, b=0x1A, op=7'b1000000, ALU model registered add, ALU_LAT=1, `res_ready`=1 → `alu_in_sel` sequence 100→010→100; `res_data`=0x71 valid 3 edges after acceptance.
- **Backpressure/full**: `res_ready`=0, push 6 commands → 5 accepted (1 in HOLD, 4 queued); `cmd_ready`=0 with `level`=4 on the 6th. Raise `res_ready` → 5 results in order.
- **Back-to-back**: 3 adds (1+2, 3+4, 5+6), `res_ready`=1 → results 3, 7, 11, spaced 3 cycles apart.
- **Illegal op**: op=7'b0000011 with macro → `res_err`=1, `res_data`=0x00, no 010 on `alu_in_sel`. Without macro → forwarded, `res_err`=0.
- **Reset mid-WAIT**: 2 commands queued, `rst`=0 during WAIT → no `res_valid` afterwards, `level`=0, `alu_in_sel`=001 then 100.
